acl_sample_sequencer: RTL and testbench

Controls the ADXL362 accelerometer on a fixed sampling period. After reset it configures the part once. It then reads the X, Y and Z axes through the byte-level SPI engine, converts each 8-bit two's-complement sample to sign plus 4-bit magnitude, and publishes the packed 15-bit word consumed by the seven-segment display driver. It owns all chip-select and byte sequencing; the SPI engine only shifts single bytes.

---
 rtl/acl_sample_sequencer.sv | 162 ++++++++++++++++
 tb/tb_acl_sample_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_sample_sequencer.sv
// rtl/acl_sample_sequencer.sv - ADXL362 configure-once / periodic XYZ read sequencer
module acl_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 10_000_000,
    parameter int DONE_TIMEOUT  = 1024
) (
    input  logic        clk100mhz,
    input  logic        rst_n,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_byte,
    output logic        spi_cs_n,
    output logic [14:0] acl_data,
    output logic        acl_valid,
    output logic        spi_err
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [3:0] {
        CFG_SETUP, CFG_CMD, CFG_ADDR, CFG_DATA, IDLE,
        RD_SETUP, RD_CMD, RD_ADDR, RD_X, RD_Y, RD_Z, UPDATE
    } state_t;

    state_t          state, state_nx;
    logic            waiting, waiting_nx;   // 0 = ISSUE phase, 1 = WAIT phase
    logic            cs_hold, cs_hold_nx;   // forces one chip-select-high cycle in CFG_SETUP
    logic [TW-1:0]   timer;
    logic            tick;
    logic            pending;
    logic [DW-1:0]   tcnt;
    logic            tmo;
    logic [7:0]      x_raw, y_raw;
    logic            byte_st;
    logic [7:0]      byte_val;
    state_t          byte_next;

    // Two's-complement byte to {sign, saturated |v|/8}
    function automatic logic [4:0] to_sm(input logic [7:0] v);
        logic [7:0] a;
        a = v[7] ? (~v + 8'd1) : v;
        return {v[7], (a >= 8'd128) ? 4'hF : 4'(a >> 3)};
    endfunction

    assign tick = (timer == TW'(SAMPLE_PERIOD - 1));
    assign tmo  = waiting && !spi_done && (tcnt == DW'(DONE_TIMEOUT - 1));

    // Free-running sample period timer
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n)    timer <= '0;
        else if (tick) timer <= '0;
        else           timer <= timer + TW'(1);
    end

    // One-deep memory of a tick that arrived while busy
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n)              pending <= 1'b0;
        else if (state == IDLE)  pending <= 1'b0;
        else if (tick)           pending <= 1'b1;
    end

    // Cycles spent waiting for spi_done in the current byte
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n)       tcnt <= '0;
        else if (waiting) tcnt <= tcnt + DW'(1);
        else              tcnt <= '0;
    end

    // State register
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CFG_SETUP;
            waiting <= 1'b0;
            cs_hold <= 1'b1;
        end else begin
            state   <= state_nx;
            waiting <= waiting_nx;
            cs_hold <= cs_hold_nx;
        end
    end

    // Next-state and transaction outputs
    always_comb begin
        state_nx    = state;
        waiting_nx  = waiting;
        cs_hold_nx  = 1'b0;
        spi_start   = 1'b0;
        spi_tx_byte = 8'h00;
        spi_cs_n    = 1'b1;
        acl_valid   = 1'b0;
        byte_st     = 1'b0;
        byte_val    = 8'h00;
        byte_next   = state;
        case (state)
            CFG_SETUP: begin
                if (!cs_hold) begin
                    spi_cs_n   = 1'b0;
                    state_nx   = CFG_CMD;
                    waiting_nx = 1'b0;
                end
            end
            CFG_CMD:  begin byte_st = 1'b1; byte_val = 8'h0A; byte_next = CFG_ADDR; end
            CFG_ADDR: begin byte_st = 1'b1; byte_val = 8'h2D; byte_next = CFG_DATA; end
            CFG_DATA: begin byte_st = 1'b1; byte_val = 8'h02; byte_next = IDLE;     end
            IDLE: begin
                if (tick || pending) state_nx = RD_SETUP;
            end
            RD_SETUP: begin
                spi_cs_n   = 1'b0;
                state_nx   = RD_CMD;
                waiting_nx = 1'b0;
            end
            RD_CMD:   begin byte_st = 1'b1; byte_val = 8'h0B; byte_next = RD_ADDR; end
            RD_ADDR:  begin byte_st = 1'b1; byte_val = 8'h08; byte_next = RD_X;    end
            RD_X:     begin byte_st = 1'b1; byte_val = 8'h00; byte_next = RD_Y;    end
            RD_Y:     begin byte_st = 1'b1; byte_val = 8'h00; byte_next = RD_Z;    end
            RD_Z:     begin byte_st = 1'b1; byte_val = 8'h00; byte_next = UPDATE;  end
            UPDATE: begin
                acl_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = CFG_SETUP;
        endcase
        if (byte_st) begin
            spi_cs_n    = 1'b0;
            spi_tx_byte = byte_val;
            if (!waiting) begin
                spi_start  = 1'b1;
                waiting_nx = 1'b1;
            end else if (spi_done) begin
                state_nx   = byte_next;
                waiting_nx = 1'b0;
            end
        end
        if (tmo) begin
            state_nx   = CFG_SETUP;
            waiting_nx = 1'b0;
            cs_hold_nx = 1'b1;
        end
    end

    // Capture axis bytes; publish the packed word as the Z byte lands
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            x_raw    <= 8'h00;
            y_raw    <= 8'h00;
            acl_data <= '0;
        end else if (waiting && spi_done) begin
            if (state == RD_X) x_raw <= spi_rx_byte;
            if (state == RD_Y) y_raw <= spi_rx_byte;
            if (state == RD_Z) acl_data <= {to_sm(x_raw), to_sm(y_raw), to_sm(spi_rx_byte)};
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n)   spi_err <= 1'b0;
        else if (tmo) spi_err <= 1'b1;
    end

endmodule

// File: tb/tb_acl_sample_sequencer.sv
// tb/tb_acl_sample_sequencer.sv - scoreboard bench for acl_sample_sequencer
module tb_acl_sample_sequencer;

    localparam int SP = 200;
    localparam int DT = 100;

    logic        clk100mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic        spi_cs_n;
    logic [14:0] acl_data;
    logic        acl_valid;
    logic        spi_err;

    acl_sample_sequencer #(.SAMPLE_PERIOD(SP), .DONE_TIMEOUT(DT)) dut (
        .clk100mhz  (clk100mhz),
        .rst_n      (rst_n),
        .spi_start  (spi_start),
        .spi_tx_byte(spi_tx_byte),
        .spi_done   (spi_done),
        .spi_rx_byte(spi_rx_byte),
        .spi_cs_n   (spi_cs_n),
        .acl_data   (acl_data),
        .acl_valid  (acl_valid),
        .spi_err    (spi_err)
    );

    always #5 clk100mhz = ~clk100mhz;

    int cycle = 0;
    always @(posedge clk100mhz) cycle <= cycle + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    function automatic logic [4:0] ref_conv(input logic [7:0] v);
        int s, a, m;
        s = int'($signed(v));
        a = (s < 0) ? -s : s;
        m = a / 8;
        if (m > 15) m = 15;
        return {(s < 0) ? 1'b1 : 1'b0, m[3:0]};
    endfunction

    // Shared model / monitor state
    int          lat = 16;
    bit          withhold_y = 0;
    bit          x_started = 0;
    int          y_start_cycle = 0;
    int          z_done_cycle = -10;
    logic [7:0]  dir_q[$];
    logic [14:0] exp_q[$];
    logic [14:0] last_data = '0;
    int          valid_cnt = 0;
    int          last_valid_cycle = -1;
    bit          check_period = 0;
    bit          check_gap = 0;
    int          cfg_seen = 0;
    logic [7:0]  cfg_seq[3] = '{8'h0A, 8'h2D, 8'h02};
    logic [7:0]  rd_seq[5]  = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};

    // SPI byte engine model: answers each start after lat cycles
    initial begin
        int         cnt;
        int         byte_idx;
        bit         busy;
        bit         rd_tx;
        bit         is_z;
        logic [7:0] x_v, y_v, z_v, rx_pend;
        busy = 0; byte_idx = 0; rd_tx = 0; is_z = 0; cnt = 0;
        x_v = 0; y_v = 0; z_v = 0; rx_pend = 0;
        forever begin
            @(negedge clk100mhz);
            spi_done = 1'b0;
            if (!rst_n) begin
                busy = 0;
                byte_idx = 0;
                continue;
            end
            if (spi_cs_n) byte_idx = 0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    spi_done    = 1'b1;
                    spi_rx_byte = rx_pend;
                    busy        = 0;
                    if (is_z) begin
                        exp_q.push_back({ref_conv(x_v), ref_conv(y_v), ref_conv(z_v)});
                        z_done_cycle = cycle;
                    end
                end
            end
            if (spi_start) begin
                if (byte_idx == 0) begin
                    rd_tx = (spi_tx_byte == 8'h0B);
                    if (rd_tx) begin
                        if (dir_q.size() >= 3) begin
                            x_v = dir_q.pop_front();
                            y_v = dir_q.pop_front();
                            z_v = dir_q.pop_front();
                        end else begin
                            x_v = 8'($urandom);
                            y_v = 8'($urandom);
                            z_v = 8'($urandom);
                        end
                    end
                end
                is_z = rd_tx && (byte_idx == 4);
                if (rd_tx && byte_idx == 2)      rx_pend = x_v;
                else if (rd_tx && byte_idx == 3) rx_pend = y_v;
                else if (is_z)                   rx_pend = z_v;
                else                             rx_pend = 8'($urandom);
                if (rd_tx && byte_idx == 2) x_started = 1;
                if (rd_tx && byte_idx == 3) y_start_cycle = cycle;
                if (rd_tx && byte_idx == 3 && withhold_y) begin
                    withhold_y = 0;
                end else begin
                    busy = 1;
                    cnt  = lat;
                end
                byte_idx++;
            end
        end
    end

    // Monitor: scoreboard pops, timing and byte-sequence checks
    initial begin
        bit         prev_cs;
        bit         prev_err;
        bit         expect_cfg;
        bit         aborted;
        logic [7:0] tx_list[$];
        logic [14:0] e;
        prev_cs = 1; prev_err = 0; expect_cfg = 1; aborted = 0;
        forever begin
            @(negedge clk100mhz);
            if (!rst_n) begin
                prev_cs = 1; prev_err = 0; expect_cfg = 1; aborted = 0;
                tx_list.delete();
                continue;
            end
            if (acl_valid) begin
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("acl_data", acl_data, e);
                    last_data = e;
                end
                check("valid_latency", cycle - z_done_cycle, 1);
                if (valid_cnt == 0) check("first_word", acl_data, 15'b010001100011111);
                if (valid_cnt == 1) check("second_word", acl_data, {5'b01111, 5'b10000, 5'b00000});
                if (check_period && last_valid_cycle >= 0) check("period", cycle - last_valid_cycle, SP);
                last_valid_cycle = cycle;
                valid_cnt++;
            end
            if (check_gap && prev_cs && !spi_cs_n) check("read_gap", cycle - last_valid_cycle, 2);
            if (prev_cs && !spi_cs_n) begin
                tx_list.delete();
                aborted = 0;
            end
            if (spi_start) begin
                check("start_cs_n", spi_cs_n, 0);
                tx_list.push_back(spi_tx_byte);
            end
            if (spi_err && !prev_err) begin
                aborted = 1;
                expect_cfg = 1;
            end
            if (!prev_cs && spi_cs_n && !aborted) begin
                if (expect_cfg) begin
                    check("cfg_len", tx_list.size(), 3);
                    for (int i = 0; i < 3 && i < tx_list.size(); i++) check("cfg_byte", tx_list[i], cfg_seq[i]);
                    cfg_seen++;
                end else begin
                    check("rd_len", tx_list.size(), 5);
                    for (int i = 0; i < 5 && i < tx_list.size(); i++) check("rd_byte", tx_list[i], rd_seq[i]);
                end
                expect_cfg = 0;
            end
            prev_cs  = spi_cs_n;
            prev_err = spi_err;
        end
    end

    task automatic wait_valids(input int n, input int budget);
        int target;
        int t;
        target = valid_cnt + n;
        t = 0;
        while (valid_cnt < target && t < budget) begin
            @(negedge clk100mhz);
            t++;
        end
        check("wait_valid_in_budget", valid_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_start"}, spi_start, 0);
        check({tag, "_spi_tx_byte"}, spi_tx_byte, 8'h00);
        check({tag, "_spi_cs_n"}, spi_cs_n, 1);
        check({tag, "_acl_data"}, acl_data, 15'h0);
        check({tag, "_acl_valid"}, acl_valid, 0);
        check({tag, "_spi_err"}, spi_err, 0);
    endtask

    // Main sequence
    initial begin
        int          t;
        int          cfg_before;
        logic [14:0] data_before;
        dir_q = '{8'h40, 8'hC0, 8'h80, 8'h7F, 8'hF9, 8'h07};

        rst_n = 1'b0;
        repeat (3) @(posedge clk100mhz);
        #1;
        check_reset_outputs("reset");
        @(negedge clk100mhz);
        rst_n = 1'b1;

        wait_valids(1, 3000);
        check("cfg_after_reset", cfg_seen, 1);
        wait_valids(2, 1000);
        check_period = 1;
        wait_valids(3, 1000);

        lat = 30;
        check_period = 0;
        wait_valids(2, 1500);
        check_period = 1;
        wait_valids(3, 1000);
        check_period = 0;

        lat = 60;
        wait_valids(2, 2000);
        check_gap = 1;
        wait_valids(4, 2000);
        check_gap = 0;

        lat = 16;
        wait_valids(1, 1000);
        data_before = last_data;
        cfg_before  = cfg_seen;
        withhold_y  = 1;
        t = 0;
        while (!spi_err && t < 3000) begin
            @(negedge clk100mhz);
            t++;
        end
        check("tmo_err", spi_err, 1);
        check("tmo_cs_n", spi_cs_n, 1);
        check("tmo_delay", cycle - y_start_cycle, DT + 1);
        repeat (70) @(negedge clk100mhz);
        check("tmo_cfg_reissue", cfg_seen, cfg_before + 1);
        check("tmo_data_kept", acl_data, data_before);
        wait_valids(2, 1000);

        x_started = 0;
        t = 0;
        while (!x_started && t < 1000) begin
            @(negedge clk100mhz);
            t++;
        end
        check("reached_rd_x", x_started, 1);
        repeat (3) @(posedge clk100mhz);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cfg_before = cfg_seen;
        repeat (2) @(negedge clk100mhz);
        rst_n = 1'b1;
        wait_valids(2, 1500);
        check("cfg_after_midrst", cfg_seen, cfg_before + 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
